rrv64_l1d_mshr_file: RTL and testbench

RRV64_L1D_MSHR_FILE -- requirements
Module: rrv64_l1d_mshr_file

---
 rtl/rrv64_l1d_mshr_file.sv | 140 ++++++++++++++
 tb/tb_rrv64_l1d_mshr_file.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrv64_l1d_mshr_file.sv
// L1D miss-status holding register file: allocates/merges misses, issues line
// fetches one at a time, and releases entries with their merge count on refill.
module rrv64_l1d_mshr_file #(
    parameter int N_ENTRY = 4,
    parameter int LINE_W  = 50,
    parameter int CNT_W   = 3,
    parameter int IDX_W   = $clog2(N_ENTRY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LINE_W-1:0] req_line,
    output logic [IDX_W-1:0]  req_idx,
    output logic              req_merged,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [LINE_W-1:0] mem_req_line,
    output logic [IDX_W-1:0]  mem_req_idx,
    input  logic              refill_valid,
    input  logic [IDX_W-1:0]  refill_idx,
    output logic              rel_valid,
    output logic [IDX_W-1:0]  rel_idx,
    output logic [LINE_W-1:0] rel_line,
    output logic [CNT_W-1:0]  rel_cnt,
    output logic              full
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            r_state [N_ENTRY];
    logic [LINE_W-1:0] r_line  [N_ENTRY];
    logic [CNT_W-1:0]  r_cnt   [N_ENTRY];

    logic              r_hold;
    logic [IDX_W-1:0]  r_hold_idx;
    logic              r_rel_valid;
    logic [IDX_W-1:0]  r_rel_idx;
    logic [LINE_W-1:0] r_rel_line;
    logic [CNT_W-1:0]  r_rel_cnt;

    logic              w_refill_hit;
    logic              w_match;
    logic [IDX_W-1:0]  w_match_idx;
    logic              w_sat;
    logic              w_free;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_iss;
    logic [IDX_W-1:0]  w_iss_idx;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_accept;

    // Entry being released this cycle is excluded from matching so the new
    // request gets a fresh entry instead of merging into a dying one.
    always_comb begin
        w_refill_hit = refill_valid && (r_state[refill_idx] == S_WAIT);
        w_match      = 1'b0;
        w_match_idx  = '0;
        w_free       = 1'b0;
        w_free_idx   = '0;
        w_iss        = 1'b0;
        w_iss_idx    = '0;
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (r_state[i] != S_IDLE && r_line[i] == req_line &&
                !(w_refill_hit && refill_idx == IDX_W'(i))) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(i);
            end
            if (r_state[i] == S_IDLE) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_state[i] == S_ISSUE) begin
                w_iss     = 1'b1;
                w_iss_idx = IDX_W'(i);
            end
        end
        w_sat     = (r_cnt[w_match_idx] == '1);
        w_sel_idx = r_hold ? r_hold_idx : w_iss_idx;
        w_accept  = req_valid && req_ready;
    end

    assign req_ready     = w_match ? !w_sat : w_free;
    assign req_merged    = w_match && !w_sat;
    assign req_idx       = w_match ? w_match_idx : w_free_idx;
    assign mem_req_valid = w_iss;
    assign mem_req_idx   = w_sel_idx;
    assign mem_req_line  = r_line[w_sel_idx];
    assign full          = !w_free;
    assign rel_valid     = r_rel_valid;
    assign rel_idx       = r_rel_idx;
    assign rel_line      = r_rel_line;
    assign rel_cnt       = r_rel_cnt;

    // A stalled fetch pins its entry index so a lower-index allocation cannot
    // swap the presented request underneath the next level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                r_state[i] <= S_IDLE;
                r_line[i]  <= '0;
                r_cnt[i]   <= '0;
            end
            r_hold      <= 1'b0;
            r_hold_idx  <= '0;
            r_rel_valid <= 1'b0;
            r_rel_idx   <= '0;
            r_rel_line  <= '0;
            r_rel_cnt   <= '0;
        end else begin
            r_rel_valid <= w_refill_hit;
            if (w_refill_hit) begin
                r_rel_idx           <= refill_idx;
                r_rel_line          <= r_line[refill_idx];
                r_rel_cnt           <= r_cnt[refill_idx];
                r_state[refill_idx] <= S_IDLE;
                r_cnt[refill_idx]   <= '0;
            end
            if (w_iss && mem_req_ready) begin
                r_state[w_sel_idx] <= S_WAIT;
            end
            r_hold     <= w_iss && !mem_req_ready;
            r_hold_idx <= w_sel_idx;
            if (w_accept) begin
                if (w_match) begin
                    r_cnt[w_match_idx] <= r_cnt[w_match_idx] + CNT_W'(1);
                end else begin
                    r_state[w_free_idx] <= S_ISSUE;
                    r_line[w_free_idx]  <= req_line;
                    r_cnt[w_free_idx]   <= CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rrv64_l1d_mshr_file.sv
// Testbench for rrv64_l1d_mshr_file: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the MSHR file.
module tb_rrv64_l1d_mshr_file;

   localparam int N      = 4;
   localparam int LW     = 50;
   localparam int CW     = 3;
   localparam int IW     = 2;
   localparam int MAXC   = (1 << CW) - 1;
   localparam int M_IDLE = 0;
   localparam int M_ISS  = 1;
   localparam int M_WAIT = 2;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [LW-1:0] req_line;
   logic [IW-1:0] req_idx;
   logic          req_merged;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [LW-1:0] mem_req_line;
   logic [IW-1:0] mem_req_idx;
   logic          refill_valid;
   logic [IW-1:0] refill_idx;
   logic          rel_valid;
   logic [IW-1:0] rel_idx;
   logic [LW-1:0] rel_line;
   logic [CW-1:0] rel_cnt;
   logic          full;

   int checkCount;
   int passCount;

   // Reference model: per-entry bookkeeping plus the fetch currently pinned by backpressure.
   int          mState [N];
   logic [LW-1:0] mLine [N];
   int          mCnt [N];
   bit          mHold;
   int          mHoldIdx;
   bit          mRelValid;
   int          mRelIdx;
   logic [LW-1:0] mRelLine;
   int          mRelCnt;

   logic          obsReady;
   logic          obsMerged;
   logic [IW-1:0] obsIdx;
   logic          obsMemValid;
   logic [IW-1:0] obsMemIdx;
   logic          obsRelValid;
   logic [IW-1:0] obsRelIdx;
   logic [CW-1:0] obsRelCnt;
   logic          obsFull;

   rrv64_l1d_mshr_file #(
      .N_ENTRY(N),
      .LINE_W (LW),
      .CNT_W  (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_line     (req_line),
      .req_idx      (req_idx),
      .req_merged   (req_merged),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_line (mem_req_line),
      .mem_req_idx  (mem_req_idx),
      .refill_valid (refill_valid),
      .refill_idx   (refill_idx),
      .rel_valid    (rel_valid),
      .rel_idx      (rel_idx),
      .rel_line     (rel_line),
      .rel_cnt      (rel_cnt),
      .full         (full)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mState[i] = M_IDLE;
         mLine[i]  = '0;
         mCnt[i]   = 0;
      end
      mHold     = 1'b0;
      mHoldIdx  = 0;
      mRelValid = 1'b0;
      mRelIdx   = 0;
      mRelLine  = '0;
      mRelCnt   = 0;
   endtask

   // Drive one cycle of inputs, check every output at the falling edge against
   // the model, then advance the model across the rising edge.
   task automatic applyStimulus(input bit rv, input logic [LW-1:0] rl, input bit mr,
                                input bit fv, input int fidx);
      int freeIdx, matchIdx, issIdx, selIdx, expIdx;
      bit effRefill, expReady, expMerged, expMemValid;
      int nState [N];
      logic [LW-1:0] nLine [N];
      int nCnt [N];
      req_valid     = rv;
      req_line      = rl;
      mem_req_ready = mr;
      refill_valid  = fv;
      refill_idx    = IW'(fidx);
      @(negedge clk);
      freeIdx  = -1;
      matchIdx = -1;
      issIdx   = -1;
      effRefill = fv && (mState[fidx] == M_WAIT);
      for (int i = N - 1; i >= 0; i--) begin
         if (mState[i] == M_IDLE) freeIdx = i;
         if (mState[i] == M_ISS) issIdx = i;
         if (mState[i] != M_IDLE && mLine[i] == rl && !(effRefill && i == fidx)) matchIdx = i;
      end
      if (matchIdx >= 0) begin
         expReady  = (mCnt[matchIdx] < MAXC);
         expMerged = expReady;
         expIdx    = matchIdx;
      end else begin
         expReady  = (freeIdx >= 0);
         expMerged = 1'b0;
         expIdx    = freeIdx;
      end
      expMemValid = (issIdx >= 0);
      selIdx = mHold ? mHoldIdx : issIdx;

      obsReady    = req_ready;
      obsMerged   = req_merged;
      obsIdx      = req_idx;
      obsMemValid = mem_req_valid;
      obsMemIdx   = mem_req_idx;
      obsRelValid = rel_valid;
      obsRelIdx   = rel_idx;
      obsRelCnt   = rel_cnt;
      obsFull     = full;

      checkOutput("full", 64'(full), 64'(freeIdx < 0));
      checkOutput("rel_valid", 64'(rel_valid), 64'(mRelValid));
      if (mRelValid) begin
         checkOutput("rel_idx", 64'(rel_idx), 64'(mRelIdx));
         checkOutput("rel_line", 64'(rel_line), 64'(mRelLine));
         checkOutput("rel_cnt", 64'(rel_cnt), 64'(mRelCnt));
      end
      checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(expMemValid));
      if (expMemValid) begin
         checkOutput("mem_req_idx", 64'(mem_req_idx), 64'(selIdx));
         checkOutput("mem_req_line", 64'(mem_req_line), 64'(mLine[selIdx]));
      end
      if (rv) begin
         checkOutput("req_ready", 64'(req_ready), 64'(expReady));
         if (expReady) begin
            checkOutput("req_merged", 64'(req_merged), 64'(expMerged));
            checkOutput("req_idx", 64'(req_idx), 64'(expIdx));
         end
      end

      for (int i = 0; i < N; i++) begin
         nState[i] = mState[i];
         nLine[i]  = mLine[i];
         nCnt[i]   = mCnt[i];
      end
      if (effRefill) begin
         mRelIdx      = fidx;
         mRelLine     = mLine[fidx];
         mRelCnt      = mCnt[fidx];
         nState[fidx] = M_IDLE;
         nCnt[fidx]   = 0;
      end
      mRelValid = effRefill;
      if (expMemValid && mr) nState[selIdx] = M_WAIT;
      mHold    = expMemValid && !mr;
      mHoldIdx = selIdx;
      if (rv && expReady) begin
         if (matchIdx >= 0) begin
            nCnt[matchIdx] = mCnt[matchIdx] + 1;
         end else begin
            nState[freeIdx] = M_ISS;
            nLine[freeIdx]  = rl;
            nCnt[freeIdx]   = 1;
         end
      end
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         mState[i] = nState[i];
         mLine[i]  = nLine[i];
         mCnt[i]   = nCnt[i];
      end
      #1;
   endtask

   task automatic idleCycles(input int n, input bit mr);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, mr, 1'b0, 0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_rel_valid"}, 64'(rel_valid), 64'd0);
      checkOutput({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
      checkOutput({tag, "_full"}, 64'(full), 64'd0);
      checkOutput({tag, "_rel_idx"}, 64'(rel_idx), 64'd0);
      checkOutput({tag, "_rel_line"}, 64'(rel_line), 64'd0);
      checkOutput({tag, "_rel_cnt"}, 64'(rel_cnt), 64'd0);
   endtask

   // Asserts reset asynchronously mid-cycle and releases it away from the clock edge.
   task automatic doReset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs(tag);
      modelReset();
      req_valid    = 1'b0;
      refill_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int waitList [$];
      int idleList [$];
      int pick;
      checkCount    = 0;
      passCount     = 0;
      rst_n         = 1'b0;
      req_valid     = 1'b0;
      req_line      = '0;
      mem_req_ready = 1'b0;
      refill_valid  = 1'b0;
      refill_idx    = '0;
      modelReset();
      @(posedge clk);
      #1;
      checkResetOutputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] alloc / issue / refill");
      applyStimulus(1'b1, 50'h100, 1'b0, 1'b0, 0);
      checkOutput("d42_ready", 64'(obsReady), 64'd1);
      checkOutput("d42_idx", 64'(obsIdx), 64'd0);
      checkOutput("d42_merged", 64'(obsMerged), 64'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
      checkOutput("d42_memvalid", 64'(obsMemValid), 64'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
      checkOutput("d42_rel_valid", 64'(obsRelValid), 64'd1);
      checkOutput("d42_rel_cnt", 64'(obsRelCnt), 64'd1);

      $display("[TB] merge saturation");
      for (int k = 0; k < 7; k++) applyStimulus(1'b1, 50'h200, 1'b0, 1'b0, 0);
      applyStimulus(1'b1, 50'h200, 1'b0, 1'b0, 0);
      checkOutput("d43_sat_ready", 64'(obsReady), 64'd0);
      applyStimulus(1'b1, 50'h210, 1'b0, 1'b0, 0);
      checkOutput("d43_other_ready", 64'(obsReady), 64'd1);
      idleCycles(2, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 0);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1);
      checkOutput("d43_rel_cnt", 64'(obsRelCnt), 64'd7);
      idleCycles(1, 1'b1);

      $display("[TB] full");
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 50'h400 + 50'(k), 1'b1, 1'b0, 0);
      idleCycles(2, 1'b1);
      checkOutput("d44_full", 64'(obsFull), 64'd1);
      applyStimulus(1'b1, 50'h404, 1'b1, 1'b0, 0);
      checkOutput("d44_fifth_blocked", 64'(obsReady), 64'd0);
      applyStimulus(1'b1, 50'h404, 1'b1, 1'b1, 2);
      checkOutput("d44_refill_cycle_blocked", 64'(obsReady), 64'd0);
      applyStimulus(1'b1, 50'h404, 1'b1, 1'b0, 0);
      checkOutput("d44_fifth_ready", 64'(obsReady), 64'd1);
      checkOutput("d44_fifth_idx", 64'(obsIdx), 64'd2);
      idleCycles(1, 1'b1);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, 1'b1, 1'b1, k);
      idleCycles(1, 1'b1);

      $display("[TB] backpressure");
      applyStimulus(1'b1, 50'h500, 1'b0, 1'b0, 0);
      applyStimulus(1'b1, 50'h501, 1'b0, 1'b0, 0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, '0, 1'b0, (k == 2), 1);
         checkOutput("d45_hold_idx", 64'(obsMemIdx), 64'd0);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
      checkOutput("d45_next_idx", 64'(obsMemIdx), 64'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 0);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1);
      idleCycles(1, 1'b1);

      $display("[TB] simultaneous refill and request");
      applyStimulus(1'b1, 50'h300, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 50'h300, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 50'h300, 1'b1, 1'b1, 0);
      checkOutput("d46_merged", 64'(obsMerged), 64'd0);
      checkOutput("d46_idx", 64'(obsIdx), 64'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
      checkOutput("d46_rel_cnt", 64'(obsRelCnt), 64'd2);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1);
      idleCycles(1, 1'b1);

      $display("[TB] reset mid-flight");
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 50'h600 + 50'(k), 1'b1, 1'b0, 0);
      idleCycles(1, 1'b1);
      doReset("d47");
      applyStimulus(1'b1, 50'h700, 1'b0, 1'b1, 1);
      checkOutput("d41_first_ready", 64'(obsReady), 64'd1);
      checkOutput("d41_first_idx", 64'(obsIdx), 64'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
      checkOutput("d47_stray_rel", 64'(obsRelValid), 64'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 0);
      idleCycles(1, 1'b1);

      $display("[TB] randomized traffic");
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit rv, mr, fv;
         int fi;
         logic [LW-1:0] rl;
         waitList.delete();
         idleList.delete();
         for (int i = 0; i < N; i++) begin
            if (mState[i] == M_WAIT) waitList.push_back(i);
            if (mState[i] == M_IDLE) idleList.push_back(i);
         end
         rv = ($urandom_range(0, 3) != 0);
         rl = 50'h800 + 50'($urandom_range(0, 5));
         mr = ($urandom_range(0, 1) == 1);
         fv = 1'b0;
         fi = 0;
         if (waitList.size() > 0 && $urandom_range(0, 2) == 0) begin
            pick = $urandom_range(0, waitList.size() - 1);
            fv = 1'b1;
            fi = waitList[pick];
         end else if (idleList.size() > 0 && $urandom_range(0, 7) == 0) begin
            pick = $urandom_range(0, idleList.size() - 1);
            fv = 1'b1;
            fi = idleList[pick];
         end
         applyStimulus(rv, rl, mr, fv, fi);
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
